// File: rtl/fir_uart_serializer.sv
// Drains FIR output words from the output FIFO and hands them byte by byte to a UART
// transmitter, respecting the send/txed handshake and an optional inter-byte idle gap.
module fir_uart_serializer #(
    parameter int WIDTH     = 32,
    parameter int MSB_FIRST = 1,
    parameter int GAP_CLKS  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ff_empty,
    output logic             o_ff_rden,
    input  logic [WIDTH-1:0] i_ff_data,
    output logic             o_uart_send,
    output logic [7:0]       o_uart_txbyte,
    input  logic             i_uart_active,
    input  logic             i_uart_txed,
    output logic             o_busy,
    output logic             o_word_done,
    output logic [15:0]      o_word_cnt
);
    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [7:0]       GAP_LOAD = 8'(GAP_CLKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD,
        S_SEND,
        S_WAIT_TX,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   word_buf_reg, word_buf_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [7:0]         gap_cnt_reg, gap_cnt_next;
    logic               ff_rden_reg, ff_rden_next;
    logic               uart_send_reg, uart_send_next;
    logic [7:0]         txbyte_reg, txbyte_next;
    logic               busy_reg, busy_next;
    logic               word_done_reg, word_done_next;
    logic [15:0]        word_cnt_reg, word_cnt_next;

    // Byte lanes in transmission order, so lane 0 is always the first byte on the wire.
    logic [7:0] byte_lane [NBYTES];
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            if (MSB_FIRST != 0) begin : g_msb
                assign byte_lane[gi] = word_buf_reg[WIDTH-1-8*gi -: 8];
            end else begin : g_lsb
                assign byte_lane[gi] = word_buf_reg[8*gi +: 8];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            word_buf_reg  <= '0;
            idx_reg       <= '0;
            gap_cnt_reg   <= '0;
            ff_rden_reg   <= 1'b0;
            uart_send_reg <= 1'b0;
            txbyte_reg    <= 8'h00;
            busy_reg      <= 1'b0;
            word_done_reg <= 1'b0;
            word_cnt_reg  <= 16'h0000;
        end else begin
            state_reg     <= state_next;
            word_buf_reg  <= word_buf_next;
            idx_reg       <= idx_next;
            gap_cnt_reg   <= gap_cnt_next;
            ff_rden_reg   <= ff_rden_next;
            uart_send_reg <= uart_send_next;
            txbyte_reg    <= txbyte_next;
            busy_reg      <= busy_next;
            word_done_reg <= word_done_next;
            word_cnt_reg  <= word_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        word_buf_next  = word_buf_reg;
        idx_next       = idx_reg;
        gap_cnt_next   = gap_cnt_reg;
        ff_rden_next   = 1'b0;
        uart_send_next = 1'b0;
        txbyte_next    = txbyte_reg;
        word_done_next = 1'b0;
        word_cnt_next  = word_cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (!i_ff_empty) begin
                    state_next   = S_RD;
                    ff_rden_next = 1'b1;
                end
            end
            S_RD: begin
                state_next = S_LD;
            end
            S_LD: begin
                word_buf_next = i_ff_data;
                idx_next      = '0;
                state_next    = S_SEND;
            end
            S_SEND: begin
                if (!i_uart_active) begin
                    uart_send_next = 1'b1;
                    txbyte_next    = byte_lane[idx_reg];
                    state_next     = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                // A txed coinciding with our own send pulse belongs to an older transfer.
                if (i_uart_txed && !uart_send_reg) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next     = idx_reg + 1'b1;
                        gap_cnt_next = GAP_LOAD;
                        state_next   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                // Count down the idle gap, then also wait for the transmitter to go quiet.
                if (gap_cnt_reg == 8'd0) begin
                    if (!i_uart_active) begin
                        state_next = S_SEND;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg - 8'd1;
                end
            end
            S_DONE: begin
                word_done_next = 1'b1;
                word_cnt_next  = word_cnt_reg + 16'd1;
                state_next     = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    assign o_ff_rden     = ff_rden_reg;
    assign o_uart_send   = uart_send_reg;
    assign o_uart_txbyte = txbyte_reg;
    assign o_busy        = busy_reg;
    assign o_word_done   = word_done_reg;
    assign o_word_cnt    = word_cnt_reg;

endmodule

// File: tb/tb_fir_uart_serializer.sv
// Bench for fir_uart_serializer: two instances (MSB-first/no gap, LSB-first/4-clock gap)
// driven by a FIFO + UART behavioural model that predicts the byte stream per word.
module tb_fir_uart_serializer;
    localparam int TX_CYC = 10;
    localparam int GAP_CFG [2] = '{0, 4};

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        ff_empty    [2];
    logic        ff_rden     [2];
    logic [31:0] ff_data     [2];
    logic        uart_send   [2];
    logic [7:0]  txbyte      [2];
    logic        uart_active [2];
    logic        uart_txed   [2];
    logic        busy        [2];
    logic        word_done   [2];
    logic [15:0] word_cnt    [2];

    fir_uart_serializer #(.WIDTH(32), .MSB_FIRST(1), .GAP_CLKS(0)) u_dut_msb (
        .clk(clk), .rst(rst),
        .i_ff_empty(ff_empty[0]), .o_ff_rden(ff_rden[0]), .i_ff_data(ff_data[0]),
        .o_uart_send(uart_send[0]), .o_uart_txbyte(txbyte[0]),
        .i_uart_active(uart_active[0]), .i_uart_txed(uart_txed[0]),
        .o_busy(busy[0]), .o_word_done(word_done[0]), .o_word_cnt(word_cnt[0])
    );

    fir_uart_serializer #(.WIDTH(32), .MSB_FIRST(0), .GAP_CLKS(4)) u_dut_lsb (
        .clk(clk), .rst(rst),
        .i_ff_empty(ff_empty[1]), .o_ff_rden(ff_rden[1]), .i_ff_data(ff_data[1]),
        .o_uart_send(uart_send[1]), .o_uart_txbyte(txbyte[1]),
        .i_uart_active(uart_active[1]), .i_uart_txed(uart_txed[1]),
        .o_busy(busy[1]), .o_word_done(word_done[1]), .o_word_cnt(word_cnt[1])
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] fq0 [$];
    logic [31:0] fq1 [$];
    logic [7:0]  eq0 [$];
    logic [7:0]  eq1 [$];

    int cyc;
    int hold_cfg [2];
    int spur_req [2];
    int spur_done [2];
    int tx_timer [2];
    int hold_timer [2];
    int sends [2];
    int rdens [2];
    int dones [2];
    int txeds [2];
    int last_txed_cyc [2];
    int last_rden_cyc [2];
    int first_send_cyc [2];
    int byte_in_word [2];
    logic word_open [2];
    logic [15:0] exp_cnt [2];

    function automatic int fifo_size(input int k);
        return (k == 0) ? fq0.size() : fq1.size();
    endfunction

    function automatic int exp_size(input int k);
        return (k == 0) ? eq0.size() : eq1.size();
    endfunction

    function automatic logic [31:0] fifo_pop(input int k);
        return (k == 0) ? fq0.pop_front() : fq1.pop_front();
    endfunction

    function automatic logic [7:0] exp_pop(input int k);
        return (k == 0) ? eq0.pop_front() : eq1.pop_front();
    endfunction

    // Instance 0 sends most significant byte first, instance 1 least significant first.
    task automatic push_word(input int k, input logic [31:0] w);
        logic [7:0] b;
        if (k == 0) fq0.push_back(w); else fq1.push_back(w);
        for (int i = 0; i < 4; i++) begin
            if (k == 0) b = 8'((w >> (8 * (3 - i))) & 32'hFF);
            else        b = 8'((w >> (8 * i)) & 32'hFF);
            if (k == 0) eq0.push_back(b); else eq1.push_back(b);
        end
        exp_cnt[k] = exp_cnt[k] + 16'd1;
    endtask

    // FIFO and UART transmitter model, evaluated on every falling edge.
    initial begin
        logic act_prev;
        logic [7:0] b;
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            ff_empty[k] = 1'b1; ff_data[k] = 32'h0;
            uart_active[k] = 1'b0; uart_txed[k] = 1'b0;
            hold_cfg[k] = 0; spur_req[k] = 0; spur_done[k] = 0;
            tx_timer[k] = 0; hold_timer[k] = 0;
            sends[k] = 0; rdens[k] = 0; dones[k] = 0; txeds[k] = 0;
            last_txed_cyc[k] = 0; last_rden_cyc[k] = 0; first_send_cyc[k] = 0;
            byte_in_word[k] = 0; word_open[k] = 1'b0; exp_cnt[k] = 16'h0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                act_prev = uart_active[k];
                if (ff_rden[k]) begin
                    vectors++;
                    if (ff_empty[k] || fifo_size(k) == 0 || word_open[k]) begin
                        miscompares++;
                        $display("FAIL rden_legal inst%0d: empty=%0b open=%0b, required empty=0 open=0",
                                 k, ff_empty[k], word_open[k]);
                    end
                    if (fifo_size(k) != 0) ff_data[k] = fifo_pop(k);
                    rdens[k]++;
                    last_rden_cyc[k] = cyc;
                    byte_in_word[k] = 0;
                    word_open[k] = 1'b1;
                end
                ff_empty[k] = (fifo_size(k) == 0);

                if (rst) begin
                    tx_timer[k] = 0; hold_timer[k] = 0;
                    uart_active[k] = 1'b0; uart_txed[k] = 1'b0;
                    word_open[k] = 1'b0;
                end else begin
                    uart_txed[k] = 1'b0;
                    if (tx_timer[k] > 0) begin
                        tx_timer[k]--;
                        if (tx_timer[k] == 0) begin
                            uart_txed[k] = 1'b1;
                            txeds[k]++;
                            last_txed_cyc[k] = cyc;
                            if (hold_cfg[k] == 0) uart_active[k] = 1'b0;
                            else hold_timer[k] = hold_cfg[k];
                        end
                    end else if (hold_timer[k] > 0) begin
                        hold_timer[k]--;
                        if (hold_timer[k] == 0) uart_active[k] = 1'b0;
                    end else if (spur_req[k] > spur_done[k] && !uart_active[k]) begin
                        uart_txed[k] = 1'b1;
                        spur_done[k]++;
                    end

                    if (uart_send[k]) begin
                        vectors++;
                        if (act_prev) begin
                            miscompares++;
                            $display("FAIL send_while_active inst%0d: active=%0b, required 0", k, act_prev);
                        end
                        vectors++;
                        if (exp_size(k) == 0) begin
                            miscompares++;
                            $display("FAIL extra_byte inst%0d: got %02h, required no byte", k, txbyte[k]);
                        end else begin
                            b = exp_pop(k);
                            if (txbyte[k] !== b) begin
                                miscompares++;
                                $display("FAIL byte inst%0d: got %02h, required %02h", k, txbyte[k], b);
                            end else begin
                                $display("inst%0d byte %0d: %02h", k, byte_in_word[k], txbyte[k]);
                            end
                        end
                        if (byte_in_word[k] == 0) begin
                            first_send_cyc[k] = cyc;
                        end else begin
                            vectors++;
                            if (cyc - last_txed_cyc[k] < GAP_CFG[k]) begin
                                miscompares++;
                                $display("FAIL gap inst%0d: %0d cycles after txed, required >= %0d",
                                         k, cyc - last_txed_cyc[k], GAP_CFG[k]);
                            end
                        end
                        byte_in_word[k]++;
                        sends[k]++;
                        uart_active[k] = 1'b1;
                        tx_timer[k] = TX_CYC;
                    end
                    if (word_done[k]) begin
                        dones[k]++;
                        word_open[k] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_drain(input int k, input int budget, input string tag);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!(fifo_size(k) == 0 && exp_size(k) == 0 && !busy[k] &&
                 tx_timer[k] == 0 && hold_timer[k] == 0) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s drain inst%0d: not finished after %0d cycles, required completion", tag, k, n);
        end
    endtask

    task automatic check_cleared(input int k, input string tag);
        vectors++;
        if (ff_rden[k] !== 1'b0 || uart_send[k] !== 1'b0 || txbyte[k] !== 8'h00 ||
            busy[k] !== 1'b0 || word_done[k] !== 1'b0 || word_cnt[k] !== 16'h0) begin
            miscompares++;
            $display("FAIL %s inst%0d: rden=%0b send=%0b byte=%02h busy=%0b done=%0b cnt=%0h, required all 0",
                     tag, k, ff_rden[k], uart_send[k], txbyte[k], busy[k], word_done[k], word_cnt[k]);
        end
    endtask

    task automatic check_counts(input int k, input string tag, input int s_base, input int s_add,
                                input int r_base, input int r_add, input int d_base, input int d_add);
        vectors++;
        if (sends[k] - s_base != s_add) begin
            miscompares++;
            $display("FAIL %s_sends inst%0d: got %0d, required %0d", tag, k, sends[k] - s_base, s_add);
        end
        vectors++;
        if (rdens[k] - r_base != r_add) begin
            miscompares++;
            $display("FAIL %s_rdens inst%0d: got %0d, required %0d", tag, k, rdens[k] - r_base, r_add);
        end
        vectors++;
        if (dones[k] - d_base != d_add) begin
            miscompares++;
            $display("FAIL %s_dones inst%0d: got %0d, required %0d", tag, k, dones[k] - d_base, d_add);
        end
        vectors++;
        if (word_cnt[k] !== exp_cnt[k]) begin
            miscompares++;
            $display("FAIL %s_word_cnt inst%0d: got %0d, required %0d", tag, k, word_cnt[k], exp_cnt[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); #2;
        push_word(0, 32'hDEADBEEF);
        repeat (5) @(negedge clk);
        #1;
        check_cleared(0, "reset");
        check_cleared(1, "reset");
        vectors++;
        if (rdens[0] != 0) begin
            miscompares++;
            $display("FAIL reset_rden: got %0d pulses, required 0", rdens[0]);
        end
    endtask

    task automatic test_single_word();
        int s0, r0, d0;
        s0 = sends[0]; r0 = rdens[0]; d0 = dones[0];
        @(negedge clk); #2;
        rst = 1'b0;
        wait_drain(0, 200, "single");
        check_counts(0, "single", s0, 4, r0, 1, d0, 1);
        vectors++;
        if (first_send_cyc[0] - last_rden_cyc[0] != 3) begin
            miscompares++;
            $display("FAIL latency rden->send: got %0d cycles, required 3",
                     first_send_cyc[0] - last_rden_cyc[0]);
        end
    endtask

    task automatic test_back_to_back();
        int s0, r0, d0;
        s0 = sends[0]; r0 = rdens[0]; d0 = dones[0];
        push_word(0, 32'h00000001);
        push_word(0, 32'hFFFFFFFF);
        push_word(0, 32'h80000000);
        wait_drain(0, 600, "b2b");
        check_counts(0, "b2b", s0, 12, r0, 3, d0, 3);
    endtask

    task automatic test_random();
        int s0, r0, d0, s1, r1, d1, n;
        s0 = sends[0]; r0 = rdens[0]; d0 = dones[0];
        s1 = sends[1]; r1 = rdens[1]; d1 = dones[1];
        n = 3 + int'($urandom_range(0, 2));
        for (int i = 0; i < n; i++) begin
            push_word(0, $urandom);
            push_word(1, $urandom);
        end
        wait_drain(0, 200 * n + 100, "random");
        wait_drain(1, 200 * n + 100, "random");
        check_counts(0, "random", s0, 4 * n, r0, n, d0, n);
        check_counts(1, "random", s1, 4 * n, r1, n, d1, n);
    endtask

    task automatic test_lsb_first();
        int s1, r1, d1;
        s1 = sends[1]; r1 = rdens[1]; d1 = dones[1];
        push_word(1, 32'h12345678);
        wait_drain(1, 300, "lsb");
        check_counts(1, "lsb", s1, 4, r1, 1, d1, 1);
    endtask

    task automatic test_gap();
        int s1, r1, d1;
        s1 = sends[1]; r1 = rdens[1]; d1 = dones[1];
        hold_cfg[1] = 6;
        spur_req[1] = spur_req[1] + 1;
        repeat (6) @(negedge clk);
        #1;
        vectors++;
        if (busy[1] !== 1'b0 || sends[1] != s1) begin
            miscompares++;
            $display("FAIL spurious_txed: busy=%0b sends=%0d, required busy=0 sends=%0d", busy[1], sends[1], s1);
        end
        push_word(1, $urandom);
        push_word(1, $urandom);
        wait_drain(1, 600, "gap");
        check_counts(1, "gap", s1, 8, r1, 2, d1, 2);
        hold_cfg[1] = 0;
    endtask

    task automatic test_reset_mid_word();
        int s0, r0, d0, tgt, n;
        push_word(0, 32'hCAFEF00D);
        tgt = txeds[0] + 2;
        n = 0;
        while (txeds[0] < tgt && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        vectors++;
        if (txeds[0] < tgt) begin
            miscompares++;
            $display("FAIL midreset_wait: got %0d txed, required %0d", txeds[0], tgt);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_cleared(0, "midreset");
        eq0.delete();
        exp_cnt[0] = 16'h0;
        exp_cnt[1] = 16'h0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        s0 = sends[0]; r0 = rdens[0]; d0 = dones[0];
        push_word(0, 32'h01020304);
        wait_drain(0, 200, "midreset");
        check_counts(0, "after_reset", s0, 4, r0, 1, d0, 1);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_random();
        test_lsb_first();
        test_gap();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
